fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Shares the single write port of the 640x480 framebuffer 2-port RAM between several pixel producers (board renderer, piece sprite blitter, cursor overlay). The read port stays owned by the VGA RGB path. Grants one write per cycle round-robin and contains a frame-clear sequencer that fills the whole buffer with one colour. Sits between the drawing engines and RAM port A, in the `clk` domain.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..8.
- `SCREEN_WIDTH`, 640: pixels per line.
- `SCREEN_HEIGHT`, 480: lines per frame.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_addr`  in  NUM_REQ*19  packed pixel addresses; requester i at bits [19i+18:19i].
- `req_data`  in  NUM_REQ*24  packed {r,g,b} pixels; requester i at bits [24i+23:24i].
- `req_ready`  out  NUM_REQ  one-hot accept; a transfer happens when valid & ready.
- `clear_start`  in  1  single-cycle pulse that starts a full-frame clear.
- `clear_color`  in  24  fill colour, sampled on the `clear_start` cycle.
- `clear_busy`  out  1  high while a clear is in progress.
- `clear_done`  out  1  one-cycle pulse after the last clear write.
- `oob_err`  out  1  one-cycle pulse when an accepted request had address >= MAX.
- `ram_addr`  out  19  RAM port A address.
- `ram_wdata`  out  24  RAM port A write data.
- `ram_we`  out  1  RAM port A write enable.

## Operation
- MAX = SCREEN_WIDTH*SCREEN_HEIGHT = 307200. Valid addresses are 0..MAX-1.
- FSM states are ARB and CLEAR. Reset state is ARB.
- ARB state:
  - Round-robin search starts at (last_grant+1) mod NUM_REQ.
  - The first requester with valid high gets `req_ready`. `req_ready` is combinational from `req_valid` and state.
  - At most one ready bit is high per cycle. All ready bits are 0 when no request is valid.
  - `last_grant` updates only on a grant. Its reset value is NUM_REQ-1, so requester 0 wins first.
- Accepted write with in-range address: the address and data are registered to `ram_addr`/`ram_wdata`, and `ram_we`=1 on the next cycle.
- Accepted write with address >= MAX: the request is still consumed (ready given). `ram_we` stays 0, and `oob_err` pulses on the next cycle.
- `clear_start` in ARB:
  - Latch `clear_color`, enter CLEAR next cycle. `clear_start` has priority over requests in that same cycle, so no ready is given.
  - `clear_start` while in CLEAR is ignored.
- CLEAR state:
  - A 19-bit counter runs 0..MAX-1, one write per cycle (`ram_we`=1, `ram_wdata`=latched colour).
  - All `req_ready`=0 and `clear_busy`=1.
  - After address MAX-1 is issued, return to ARB and pulse `clear_done` coincident with the final `ram_we` cycle. The counter resets to 0.
- Requests held during CLEAR stay pending (requester must hold valid/addr/data). Round-robin resumes from the preserved `last_grant`.
- Reset mid-clear aborts the clear. No resume.

## Timing
- Reset values: `req_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `clear_busy`=0, `clear_done`=0, `oob_err`=0, `last_grant`=NUM_REQ-1, clear counter=0.
- Request latency: accept on cycle N, RAM write on cycle N+1. Sustained throughput is 1 write/cycle.
- Clear timing: `clear_start` on cycle N, `clear_busy` high from N+1.
  - Writes to addresses 0..307199 occur on cycles N+2..N+307201, with `clear_done` on N+307201.
  - `clear_busy` falls at N+307202. Requests can be accepted on N+307202.
- `ram_we`, `ram_addr`, `ram_wdata` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `fb_pkg`:
  - `FB_WIDTH`, `FB_HEIGHT`, `FB_DEPTH`=307200, `FB_ADDR_W`=19.
  - `pixel_t` (24-bit packed r/g/b, 8 each).
  - Arbiter state enum `fb_arb_state_e` {ARB, CLEAR}.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`: takes `req` and `last_grant`, returns a one-hot `grant` and encoded index. It is purely combinational; the pointer register lives in the parent.

## Test plan
- Single requester: after reset, req 1 valid with addr=100, data=0xFF0000 → ready[1] same cycle; next cycle `ram_we`=1, `ram_addr`=100, `ram_wdata`=0xFF0000.
- Fairness: all 3 requesters held valid for 6 cycles → grant order 0,1,2,0,1,2 with one `ram_we` per cycle; never two ready bits high.
- Out of range: req 0 addr=307200 → ready[0]=1, `ram_we`=0 next cycle, `oob_err` pulse; addr=307199 → written normally.
- Clear: `clear_start` with colour 0x00FF00 while req 2 is valid → no ready given; 307200 consecutive writes with addresses 0..307199 all 0x00FF00; `clear_done` on the last write; req 2 granted the cycle after `clear_busy` falls. A second `clear_start` mid-clear has no effect.
- Reset mid-clear: assert `reset_n`=0 at address 1000 → all outputs return to reset values asynchronously; after release, req 0 is granted first.
- Random: constrained-random valid/addr/data on all ports against a scoreboard model of the RAM → every accepted in-range write appears exactly once, in acceptance order.

Source files
------------

// File: rtl/fb_pkg.sv
// Framebuffer-wide constants and types shared by the drawing engines,
// the write arbiter and the VGA read path.
package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 19;

    // One framebuffer pixel, 8 bits per channel.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Write-port owner: normal arbitration or the frame-clear sequencer.
    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } fb_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search begins one past the previous
// winner, so the previous winner has the lowest priority this cycle. The
// pointer register is owned by the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] pos;

    // Scan requesters in rotated order and keep only the first valid one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owner of framebuffer RAM port A. Grants one producer write per cycle in
// round-robin order, drops out-of-range writes with an error pulse, and can
// take over the port to fill the whole frame with a single colour.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int SCREEN_WIDTH  = FB_WIDTH,
    parameter int SCREEN_HEIGHT = FB_HEIGHT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*19-1:0]     req_addr,
    input  logic [NUM_REQ*24-1:0]     req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clear_start,
    input  logic [23:0]               clear_color,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      oob_err,
    output logic [18:0]               ram_addr,
    output logic [23:0]               ram_wdata,
    output logic                      ram_we
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR =
        FB_ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

    fb_arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [FB_ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    pixel_t                 clr_color_q, clr_color_d;
    logic [FB_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [23:0]            ram_wdata_q, ram_wdata_d;
    logic                   ram_we_q, ram_we_d;
    logic                   clear_done_q, clear_done_d;
    logic                   oob_err_q, oob_err_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [FB_ADDR_W-1:0]   sel_addr;
    logic [23:0]            sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Route the winning requester's address and pixel to the write path.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*FB_ADDR_W +: FB_ADDR_W];
                sel_data = req_data[i*24 +: 24];
            end
        end
    end

    // Next-state logic: arbitration, clear sequencing and the registered
    // RAM port contents. Ready is held low while reset is asserted.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        clr_cnt_d    = clr_cnt_q;
        clr_color_d  = clr_color_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        clear_done_d = 1'b0;
        oob_err_d    = 1'b0;
        req_ready    = '0;
        case (state_q)
            ARB: begin
                if (clear_start) begin
                    // A clear wins over any request presented in the same cycle.
                    clr_color_d = clear_color;
                    clr_cnt_d   = '0;
                    state_d     = CLEAR;
                end else if (|grant && reset_n) begin
                    req_ready    = grant;
                    last_grant_d = grant_idx;
                    if (sel_addr <= LAST_ADDR) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = sel_addr;
                        ram_wdata_d = sel_data;
                    end else begin
                        oob_err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (clear_done_q) begin
                    // Trailing cycle after the last fill write; port is handed back next.
                    state_d = ARB;
                end else begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = clr_cnt_q;
                    ram_wdata_d = clr_color_q;
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_cnt_d    = '0;
                        clear_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and output registers; an asserted reset aborts any clear in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            clr_cnt_q    <= '0;
            clr_color_q  <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            clear_done_q <= 1'b0;
            oob_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_color_q  <= clr_color_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            clear_done_q <= clear_done_d;
            oob_err_q    <= oob_err_d;
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_done = clear_done_q;
    assign oob_err    = oob_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a reduced 32x10 frame so that a full
// clear stays short. Finishes with a constrained-random scoreboard phase.
module tb_fb_write_arbiter;

    localparam int NREQ = 3;
    localparam int SW   = 32;
    localparam int SH   = 10;
    localparam int MAX  = SW * SH;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*19-1:0]   req_addr;
    logic [NREQ*24-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 clear_start;
    logic [23:0]          clear_color;
    logic                 clear_busy;
    logic                 clear_done;
    logic                 oob_err;
    logic [18:0]          ram_addr;
    logic [23:0]          ram_wdata;
    logic                 ram_we;

    int checks   = 0;
    int failures = 0;

    fb_write_arbiter #(
        .NUM_REQ       (NREQ),
        .SCREEN_WIDTH  (SW),
        .SCREEN_HEIGHT (SH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .oob_err     (oob_err),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [18:0] a, input logic [23:0] d);
        req_valid[i]          = v;
        req_addr[i*19 +: 19]  = a;
        req_data[i*24 +: 24]  = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [42:0] sb[$];
        logic [42:0] exp_wr;
        logic [NREQ-1:0] exp_rdy;
        logic [18:0] ra;
        logic [23:0] rd;
        logic [18:0] wa;
        logic [23:0] wd;
        int lg;
        int win;
        bit pend_oob;

        reset_n     = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;
        clear_color = '0;
        #1 reset_n = 1'b0;
        #2;
        // ---- reset values
        chk("rst_ready", req_ready, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_oob", oob_err, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ---- fairness: all three held valid for six cycles
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 19'(20 + i), 24'h111111 * 24'(i + 1));
        for (int c = 0; c < 6; c++) begin
            if (c > 0)
                chk("fair_wr", {ram_we, ram_addr, ram_wdata},
                    {1'b1, 19'(20 + (c - 1) % 3), 24'h111111 * 24'((c - 1) % 3 + 1)});
            #1;
            chk("fair_ready", req_ready, 3'b001 << (c % 3));
            tick();
        end
        req_valid = '0;
        chk("fair_last_wr", {ram_we, ram_addr, ram_wdata}, {1'b1, 19'd22, 24'h333333});

        // ---- single requester
        set_req(1, 1'b1, 19'd100, 24'hFF0000);
        #1;
        chk("single_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        chk("single_wr", {ram_we, ram_addr, ram_wdata}, {1'b1, 19'd100, 24'hFF0000});
        #1;
        chk("idle_ready", req_ready, 3'b000);
        tick();
        chk("idle_we", ram_we, 0);

        // ---- out of range, then the last valid address
        set_req(0, 1'b1, 19'(MAX), 24'hABCDEF);
        #1;
        chk("oob_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("oob_we", ram_we, 0);
        chk("oob_pulse", oob_err, 1);
        tick();
        chk("oob_pulse_end", oob_err, 0);
        set_req(0, 1'b1, 19'(MAX - 1), 24'h123456);
        #1;
        chk("edge_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("edge_wr", {ram_we, ram_addr, ram_wdata, oob_err}, {1'b1, 19'(MAX - 1), 24'h123456, 1'b0});

        // ---- full clear while requester 2 waits
        set_req(2, 1'b1, 19'd5, 24'h0000FF);
        clear_start = 1'b1;
        clear_color = 24'h00FF00;
        #1;
        chk("clr_start_ready", req_ready, 3'b000);
        tick();
        clear_start = 1'b0;
        clear_color = 24'hDEAD00;
        chk("clr_busy_rise", {clear_busy, ram_we}, {1'b1, 1'b0});
        #1;
        chk("clr_ready0", req_ready, 3'b000);
        for (int k = 0; k < MAX; k++) begin
            tick();
            chk("clr_wr", {ram_we, ram_addr, ram_wdata, clear_done},
                {1'b1, 19'(k), 24'h00FF00, 1'(k == MAX - 1)});
            if (k == 50) begin
                clear_start = 1'b1;
                clear_color = 24'hFFFFFF;
            end
            if (k == 51) clear_start = 1'b0;
            if (k == 100 || k == MAX - 1) begin
                chk("clr_busy_mid", clear_busy, 1);
                #1;
                chk("clr_ready_mid", req_ready, 3'b000);
            end
        end
        tick();
        chk("clr_end", {clear_busy, ram_we, clear_done}, {1'b0, 1'b0, 1'b0});
        #1;
        chk("clr_resume_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        chk("clr_resume_wr", {ram_we, ram_addr, ram_wdata}, {1'b1, 19'd5, 24'h0000FF});

        // ---- reset in the middle of a clear
        clear_start = 1'b1;
        clear_color = 24'h0F0F0F;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 201; k++) tick();
        chk("mid_clr_addr", {ram_we, ram_addr, ram_wdata}, {1'b1, 19'd200, 24'h0F0F0F});
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 19'(40 + i), 24'h0A0B00 + 24'(i));
        #2 reset_n = 1'b0;
        #1;
        chk("arst_outs", {ram_we, ram_addr, ram_wdata, clear_busy, clear_done, oob_err}, 64'd0);
        chk("arst_ready", req_ready, 3'b000);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("post_rst_wr", {ram_we, ram_addr, ram_wdata, clear_busy}, {1'b1, 19'd40, 24'h0A0B00, 1'b0});
        tick();

        // ---- constrained random against a round-robin and RAM scoreboard
        lg = 0;
        pend_oob = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (sb.size() > 0) begin
                exp_wr = sb.pop_front();
                chk("rnd_wr", {ram_we, ram_addr, ram_wdata}, {1'b1, exp_wr});
            end else begin
                chk("rnd_idle_we", ram_we, 0);
            end
            chk("rnd_oob", oob_err, pend_oob);
            pend_oob = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) ra = 19'(MAX + $urandom_range(0, 500));
                else ra = 19'($urandom_range(0, MAX - 1));
                rd = 24'($urandom);
                set_req(i, 1'($urandom_range(0, 1)), ra, rd);
            end
            #1;
            exp_rdy = '0;
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (win < 0 && req_valid[(lg + k) % NREQ]) win = (lg + k) % NREQ;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("rnd_ready", req_ready, exp_rdy);
            if (win >= 0) begin
                lg = win;
                wa = req_addr[win*19 +: 19];
                wd = req_data[win*24 +: 24];
                if (int'(wa) < MAX) sb.push_back({wa, wd});
                else pend_oob = 1'b1;
            end
            tick();
        end
        req_valid = '0;
        if (sb.size() > 0) begin
            exp_wr = sb.pop_front();
            chk("rnd_drain_wr", {ram_we, ram_addr, ram_wdata}, {1'b1, exp_wr});
        end else begin
            chk("rnd_drain_idle", ram_we, 0);
        end
        chk("rnd_drain_oob", oob_err, pend_oob);
        chk("rnd_sb_empty", 64'(sb.size()), 0);
        tick();
        chk("rnd_final_idle", {ram_we, oob_err}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
